// File: rtl/fifo_wr_ingress.sv
// rtl/fifo_wr_ingress.sv - write-side ingress: 2-entry skid buffer to winc/wdata plus registered fill level
module fifo_wr_ingress #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 4,
   parameter int AFULL_THRESH = 12
) (
   input  logic                  wclk,
   input  logic                  wrst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  winc,
   output logic [DATA_WIDTH-1:0] wdata,
   input  logic                  wfull,
   input  logic [ADDR_WIDTH:0]   wptr,
   input  logic [ADDR_WIDTH:0]   wq2_rptr,
   output logic [ADDR_WIDTH:0]   wlevel,
   output logic                  walmost_full
);

   localparam logic [ADDR_WIDTH:0] DEPTH     = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
   localparam logic [ADDR_WIDTH:0] AFULL_LVL = (ADDR_WIDTH+1)'(AFULL_THRESH);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] main_q, main_d;
   logic [DATA_WIDTH-1:0] skid_q, skid_d;
   logic                  s_ready_q;
   logic [ADDR_WIDTH:0]   wlevel_q, wlevel_d;
   logic                  walmost_full_q, walmost_full_d;
   logic                  accept;
   logic                  pop;

   // Each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
      logic [ADDR_WIDTH:0] b;
      b = '0;
      for (int i = 0; i <= ADDR_WIDTH; i++) begin
         b[i] = ^(g >> i);
      end
      return b;
   endfunction

   assign accept       = s_valid & s_ready_q;
   assign winc         = (state_q != ST_EMPTY) & ~wfull;
   assign pop          = winc;
   assign wdata        = main_q;
   assign s_ready      = s_ready_q;
   assign wlevel       = wlevel_q;
   assign walmost_full = walmost_full_q;

   // Skid FSM next state: main always holds the oldest word, skid the younger one.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d = ST_ONE;
               main_d  = s_data;
            end
         end
         ST_ONE: begin
            if (accept && !pop) begin
               state_d = ST_TWO;
               skid_d  = s_data;
            end else if (pop && !accept) begin
               state_d = ST_EMPTY;
            end else if (accept && pop) begin
               main_d = s_data;
            end
         end
         ST_TWO: begin
            if (pop) begin
               state_d = ST_ONE;
               main_d  = skid_q;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   // Fill level from the pointer difference; the extra MSB makes modular subtraction handle wrap.
   always_comb begin
      logic [ADDR_WIDTH:0] diff;
      diff           = gray2bin(wptr) - gray2bin(wq2_rptr);
      wlevel_d       = (diff > DEPTH) ? DEPTH : diff;
      walmost_full_d = (wlevel_d >= AFULL_LVL);
   end

   // State, data and flag registers; reset discards any buffered words.
   always_ff @(posedge wclk) begin
      if (wrst) begin
         state_q        <= ST_EMPTY;
         main_q         <= '0;
         skid_q         <= '0;
         s_ready_q      <= 1'b0;
         wlevel_q       <= '0;
         walmost_full_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         main_q         <= main_d;
         skid_q         <= skid_d;
         s_ready_q      <= (state_d != ST_TWO);
         wlevel_q       <= wlevel_d;
         walmost_full_q <= walmost_full_d;
      end
   end

endmodule
